// File: rtl/l2_tlb_ram_ctrl.sv
// Port sequencer for the single-port L2 TLB RAM: arbitrates lookup reads against
// PTW refill writes and runs full-array invalidate sweeps on flush or after reset.
module l2_tlb_ram_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 44,
  parameter int STARVE_LIMIT   = 4,
  parameter int FLUSH_ON_RESET = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_resp_valid_o,
  output logic [DATA_W-1:0] rd_resp_data_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              flush_req_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic [ADDR_W-1:0] RW0_addr_o,
  output logic              RW0_en_o,
  output logic              RW0_wmode_o,
  output logic [DATA_W-1:0] RW0_wdata_o,
  input  logic [DATA_W-1:0] RW0_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0]        LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_ptr_q, sweep_ptr_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rd_resp_valid_q;
  logic              flush_busy_q;
  logic              flush_done_q;

  logic              arb_en;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              sweep_wr;

  // A flush request in IDLE steals the cycle; DONE ignores flush and arbitrates normally.
  assign arb_en   = !reset_i && ((state_q == DONE) || ((state_q == IDLE) && !flush_req_i));
  assign rd_gnt   = arb_en && rd_valid_i && (!wr_valid_i || (starve_cnt_q == LIMIT));
  assign wr_gnt   = arb_en && wr_valid_i && !rd_gnt;
  assign sweep_wr = !reset_i && (state_q == SWEEP);

  always_comb begin
    state_d      = state_q;
    sweep_ptr_d  = sweep_ptr_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE:    if (flush_req_i) state_d = SWEEP;
      SWEEP: begin
        sweep_ptr_d = sweep_ptr_q + 1'b1;
        if (sweep_ptr_q == LAST_PTR) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rd_valid_i || rd_gnt) begin
      starve_cnt_d = '0;
    end else if (wr_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= (FLUSH_ON_RESET != 0) ? SWEEP : IDLE;
      sweep_ptr_q     <= '0;
      starve_cnt_q    <= '0;
      rd_resp_valid_q <= 1'b0;
      flush_busy_q    <= (FLUSH_ON_RESET != 0);
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_ptr_q     <= sweep_ptr_d;
      starve_cnt_q    <= starve_cnt_d;
      rd_resp_valid_q <= rd_gnt;
      flush_busy_q    <= (state_d == SWEEP);
      flush_done_q    <= (state_d == DONE);
    end
  end

  assign rd_ready_o      = rd_gnt;
  assign wr_ready_o      = wr_gnt;
  assign RW0_en_o        = sweep_wr || rd_gnt || wr_gnt;
  assign RW0_wmode_o     = sweep_wr || wr_gnt;
  assign RW0_addr_o      = sweep_wr ? sweep_ptr_q : (wr_gnt ? wr_addr_i : rd_addr_i);
  assign RW0_wdata_o     = wr_gnt ? wr_data_i : '0;

  // Response is dropped while reset is held so nothing in flight leaks out.
  assign rd_resp_valid_o = rd_resp_valid_q && !reset_i;
  assign rd_resp_data_o  = RW0_rdata_i;
  assign flush_busy_o    = flush_busy_q;
  assign flush_done_o    = flush_done_q;

endmodule

// File: tb/tb_l2_tlb_ram_ctrl.sv
// Scoreboard bench for l2_tlb_ram_ctrl: a behavioural RAM plus a reference model of
// the arbitration/sweep rules; read responses are checked by an independent monitor.
module tb_l2_tlb_ram_ctrl;

  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 44;
  localparam int STARVE_LIMIT   = 4;
  localparam int FLUSH_ON_RESET = 1;
  localparam int DEPTH          = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rdValid = 1'b0;
  logic [ADDR_W-1:0] rdAddr = '0;
  logic              wrValid = 1'b0;
  logic [ADDR_W-1:0] wrAddr = '0;
  logic [DATA_W-1:0] wrData = '0;
  logic              flushReq = 1'b0;

  logic              rd_ready_o, wr_ready_o, rd_resp_valid_o;
  logic [DATA_W-1:0] rd_resp_data_o;
  logic              flush_busy_o, flush_done_o;
  logic [ADDR_W-1:0] RW0_addr_o;
  logic              RW0_en_o, RW0_wmode_o;
  logic [DATA_W-1:0] RW0_wdata_o;
  logic [DATA_W-1:0] ramRdata = '0;

  l2_tlb_ram_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .FLUSH_ON_RESET(FLUSH_ON_RESET)
  ) dut (
    .clock_i(clock), .reset_i(reset),
    .rd_valid_i(rdValid), .rd_ready_o(rd_ready_o), .rd_addr_i(rdAddr),
    .rd_resp_valid_o(rd_resp_valid_o), .rd_resp_data_o(rd_resp_data_o),
    .wr_valid_i(wrValid), .wr_ready_o(wr_ready_o), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .flush_req_i(flushReq), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .RW0_addr_o(RW0_addr_o), .RW0_en_o(RW0_en_o), .RW0_wmode_o(RW0_wmode_o),
    .RW0_wdata_o(RW0_wdata_o), .RW0_rdata_i(ramRdata)
  );

  always #5 clock = ~clock;

  int cycleNum = 0;
  always @(posedge clock) cycleNum <= cycleNum + 1;

  // Behavioural single-port RAM, preloaded with garbage so the sweep is observable.
  logic [DATA_W-1:0] ramMem [DEPTH];
  initial begin
    logic [63:0] r;
    foreach (ramMem[i]) begin
      r = {$urandom(), $urandom()};
      ramMem[i] = r[DATA_W-1:0];
    end
  end
  always @(posedge clock) begin
    if (RW0_en_o) begin
      if (RW0_wmode_o) ramMem[RW0_addr_o] <= RW0_wdata_o;
      else             ramRdata <= ramMem[RW0_addr_o];
    end
  end

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t             expQ[$];
  resp_t             monEntry;
  int                total = 0;
  int                bad = 0;
  int                doneCount = 0;

  logic [DATA_W-1:0] modelMem [DEPTH];
  bit                mInSweep = 1'b0;
  int                mSweepIdx = 0;
  bit                mDone = 1'b0;
  int                mLoss = 0;

  bit                lastRdReady, lastWrReady, lastDone, lastRespValid, lastEn;
  logic [DATA_W-1:0] lastRespData;
  logic [ADDR_W-1:0] lastAddr;

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNum);
    end
  endfunction

  // Reference model: one call per clock cycle, evaluated on the falling edge.
  function automatic void checkCycle();
    bit expR, expW, goSweep;
    lastRdReady   = rd_ready_o;
    lastWrReady   = wr_ready_o;
    lastDone      = flush_done_o;
    lastRespValid = rd_resp_valid_o;
    lastRespData  = rd_resp_data_o;
    lastEn        = RW0_en_o;
    lastAddr      = RW0_addr_o;
    if (flush_done_o && !reset) doneCount++;
    if (reset) begin
      checkOutput("rstRdReady", 64'(rd_ready_o), 0);
      checkOutput("rstWrReady", 64'(wr_ready_o), 0);
      checkOutput("rstRamEn", 64'(RW0_en_o), 0);
      checkOutput("rstRespValid", 64'(rd_resp_valid_o), 0);
      mInSweep  = (FLUSH_ON_RESET != 0);
      mSweepIdx = 0;
      mDone     = 1'b0;
      mLoss     = 0;
      expQ.delete();
    end else if (mInSweep) begin
      checkOutput("sweepRdReady", 64'(rd_ready_o), 0);
      checkOutput("sweepWrReady", 64'(wr_ready_o), 0);
      checkOutput("sweepEn", 64'(RW0_en_o), 1);
      checkOutput("sweepWmode", 64'(RW0_wmode_o), 1);
      checkOutput("sweepAddr", 64'(RW0_addr_o), 64'(mSweepIdx));
      checkOutput("sweepWdata", 64'(RW0_wdata_o), 0);
      checkOutput("sweepBusy", 64'(flush_busy_o), 1);
      checkOutput("sweepDone", 64'(flush_done_o), 0);
      if (!rdValid) mLoss = 0;
      if (mSweepIdx == DEPTH - 1) begin
        mInSweep  = 1'b0;
        mDone     = 1'b1;
        mSweepIdx = 0;
        foreach (modelMem[i]) modelMem[i] = '0;
      end else begin
        mSweepIdx++;
      end
    end else begin
      checkOutput("idleBusy", 64'(flush_busy_o), 0);
      checkOutput("donePulse", 64'(flush_done_o), 64'(mDone));
      goSweep = !mDone && flushReq;
      if (goSweep) begin
        expR = 1'b0;
        expW = 1'b0;
      end else if (rdValid && wrValid) begin
        expR = (mLoss == STARVE_LIMIT);
        expW = !expR;
      end else begin
        expR = rdValid;
        expW = wrValid;
      end
      checkOutput("rdReady", 64'(rd_ready_o), 64'(expR));
      checkOutput("wrReady", 64'(wr_ready_o), 64'(expW));
      checkOutput("ramEn", 64'(RW0_en_o), 64'(expR || expW));
      checkOutput("ramWmode", 64'(RW0_wmode_o), 64'(expW));
      if (expW) begin
        checkOutput("wrAddrOut", 64'(RW0_addr_o), 64'(wrAddr));
        checkOutput("wrDataOut", 64'(RW0_wdata_o), 64'(wrData));
        modelMem[wrAddr] = wrData;
      end
      if (expR) begin
        checkOutput("rdAddrOut", 64'(RW0_addr_o), 64'(rdAddr));
        checkOutput("rdWdataZero", 64'(RW0_wdata_o), 0);
        expQ.push_back('{cycleNum, modelMem[rdAddr]});
      end
      if (!rdValid || expR) mLoss = 0;
      else if (expW && mLoss < STARVE_LIMIT) mLoss++;
      mDone = 1'b0;
      if (goSweep) mInSweep = 1'b1;
    end
  endfunction

  // Monitor: every presented response must match the oldest outstanding read, one cycle on.
  always @(negedge clock) begin
    if (!reset && rd_resp_valid_o) begin
      if (expQ.size() == 0) begin
        checkOutput("respUnexpected", 64'(rd_resp_valid_o), 0);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("respLatency", 64'(cycleNum), 64'(monEntry.cyc + 1));
        checkOutput("respData", 64'(rd_resp_data_o), 64'(monEntry.data));
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    checkCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit rv, input logic [ADDR_W-1:0] ra, input bit wv,
                               input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input bit fr);
    rdValid  = rv;
    rdAddr   = ra;
    wrValid  = wv;
    wrAddr   = wa;
    wrData   = wd;
    flushReq = fr;
  endtask

  task automatic waitGrant(input bit isWrite, input int limit, input string name);
    int n = 0;
    bit granted = 1'b0;
    while (!granted && n < limit) begin
      tick();
      n++;
      granted = isWrite ? lastWrReady : lastRdReady;
    end
    checkOutput(name, 64'(granted), 1);
  endtask

  task automatic waitDone(input int limit, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = lastDone;
    end
    checkOutput(name, 64'(seen), 1);
  endtask

  task automatic readBack(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string name);
    applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0);
    waitGrant(1'b0, 20, {name, "Grant"});
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput({name, "Valid"}, 64'(lastRespValid), 1);
    checkOutput({name, "Data"}, 64'(lastRespData), 64'(exp));
  endtask

  initial begin
    int doneBase;
    bit doneSeen;
    int n;
    logic [63:0] r;

    applyStimulus(1'b1, 10'h3, 1'b1, 10'h4, 44'h1, 1'b0);
    reset = 1'b1;
    repeat (3) tick();

    // Power-on sweep: 1024 zero writes, then the done pulse.
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (DEPTH) tick();
    checkOutput("noDoneDuringSweep", 64'(doneCount), 0);
    tick();
    checkOutput("doneAt1025", 64'(lastDone), 1);

    applyStimulus(1'b0, '0, 1'b1, 10'h155, 44'hABCDEADBEEF, 1'b0);
    waitGrant(1'b1, 20, "write155Grant");
    readBack(10'h155, 44'hABCDEADBEEF, "read155");
    tick();

    // Both requesters held: four writes then a forced read, repeating.
    for (int i = 0; i < 15; i++) begin
      r = {$urandom(), $urandom()};
      applyStimulus(1'b1, 10'h10, 1'b1, 10'h11, r[DATA_W-1:0], 1'b0);
      tick();
      checkOutput("starvePattern", 64'({lastRdReady, lastWrReady}), (i % 5 == 4) ? 64'h2 : 64'h1);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) tick();

    // Flush with a coalesced second request at sweep pointer 300.
    doneBase = doneCount;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (300) tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    waitDone(1100, "flushDone");
    repeat (5) tick();
    checkOutput("singleDone", 64'(doneCount - doneBase), 1);
    readBack(10'h155, '0, "read155AfterFlush");
    tick();

    // Reset in the middle of a sweep restarts it from address 0.
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (500) tick();
    applyStimulus(1'b1, 10'h5, 1'b1, 10'h6, 44'h77, 1'b0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("restartEn", 64'(lastEn), 1);
    checkOutput("restartAddr", 64'(lastAddr), 0);
    waitDone(1100, "restartDone");
    repeat (2) tick();

    // Flush and write together in IDLE: write waits until the done cycle.
    applyStimulus(1'b0, '0, 1'b1, 10'h20, 44'h123456789AB, 1'b1);
    tick();
    checkOutput("flushBlocksWrite", 64'(lastWrReady), 0);
    applyStimulus(1'b0, '0, 1'b1, 10'h20, 44'h123456789AB, 1'b0);
    doneSeen = 1'b0;
    n = 0;
    lastWrReady = 1'b0;
    while (!lastWrReady && n < 1100) begin
      tick();
      n++;
      if (lastDone) doneSeen = 1'b1;
    end
    checkOutput("writeAfterFlushGrant", 64'(lastWrReady), 1);
    checkOutput("writeAfterDone", 64'(doneSeen), 1);
    readBack(10'h20, 44'h123456789AB, "read20");
    tick();

    // Random traffic on a small address window with rare flushes.
    for (int i = 0; i < 1500; i++) begin
      r = {$urandom(), $urandom()};
      applyStimulus(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
                    r[DATA_W-1:0], ($urandom_range(0, 299) == 0));
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    n = 0;
    while (mInSweep && n < 1100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checkOutput("respQueueEmpty", 64'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
